// File: rtl/fc_pkg.sv
// Shared FC-layer constants: lane count, beats per layer, accumulator width,
// layer encoding common with the quantizer, and the accumulator FSM encoding.
package fc_pkg;

  localparam int unsigned LANES     = 4;
  localparam int unsigned FC1_BEATS = 200;
  localparam int unsigned FC2_BEATS = 125;
  localparam int unsigned ACC_W     = 32;
  localparam int unsigned ACT_W     = 8;
  localparam int unsigned PROD_W    = 16;
  localparam int unsigned SUM_W     = PROD_W + $clog2(LANES);
  localparam int unsigned MAX_BEATS = (FC1_BEATS > FC2_BEATS) ? FC1_BEATS : FC2_BEATS;
  localparam int unsigned CNT_W     = $clog2(MAX_BEATS + 1);

  localparam logic FC1_STATE = 1'b0;
  localparam logic FC2_STATE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fc_fsm_e;

  // Index of the final beat of a neuron for the given layer.
  function automatic logic [CNT_W-1:0] last_beat(input logic layer);
    return (layer == FC2_STATE) ? CNT_W'(FC2_BEATS - 1) : CNT_W'(FC1_BEATS - 1);
  endfunction

endpackage

// File: rtl/fc_mac_lanes.sv
// Combinational lane multipliers (feeding the stage-1 product register) and
// the adder tree that reduces the registered products to one beat sum.
module fc_mac_lanes
  import fc_pkg::*;
(
  input  logic [ACT_W*LANES-1:0]  act_i,
  input  logic [ACT_W*LANES-1:0]  wgt_i,
  input  logic [PROD_W*LANES-1:0] prod_q_i,
  output logic [PROD_W*LANES-1:0] prod_o,
  output logic [SUM_W-1:0]        sum_o
);

  logic [PROD_W-1:0] a_ext [LANES];
  logic [PROD_W-1:0] w_ext [LANES];
  logic [PROD_W-1:0] p_q   [LANES];

  // Operands sign-extended to product width; the low 16 bits of the product
  // are exact because every 8x8 signed product fits in 16 signed bits.
  always_comb begin
    prod_o = '0;
    for (int i = 0; i < LANES; i++) begin
      a_ext[i] = {{(PROD_W-ACT_W){act_i[ACT_W*i+ACT_W-1]}}, act_i[ACT_W*i +: ACT_W]};
      w_ext[i] = {{(PROD_W-ACT_W){wgt_i[ACT_W*i+ACT_W-1]}}, wgt_i[ACT_W*i +: ACT_W]};
      prod_o[PROD_W*i +: PROD_W] = a_ext[i] * w_ext[i];
    end
  end

  always_comb begin
    sum_o = '0;
    for (int i = 0; i < LANES; i++) begin
      p_q[i] = prod_q_i[PROD_W*i +: PROD_W];
      sum_o  = sum_o + {{(SUM_W-PROD_W){p_q[i][PROD_W-1]}}, p_q[i]};
    end
  end

endmodule

// File: rtl/fc_accumulator.sv
// FC multiply-accumulate stage: bias plus an 8-bit dot product per job, with a
// registered product stage and a registered result for the downstream quantizer.
module fc_accumulator
  import fc_pkg::*;
(
  input  logic                   clk,
  input  logic                   srst,
  input  logic                   fc_state,
  input  logic                   start,
  input  logic [ACC_W-1:0]       bias,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ACT_W*LANES-1:0] act,
  input  logic [ACT_W*LANES-1:0] wgt,
  output logic                   busy,
  output logic                   acc_valid,
  output logic [ACC_W-1:0]       acc_data,
  output logic                   acc_state
);

  fc_fsm_e                   state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [ACC_W-1:0]          acc_q, acc_d;
  logic [PROD_W*LANES-1:0]   prod_q, prod_d;
  logic [ACC_W-1:0]          acc_data_q, acc_data_d;
  logic                      acc_state_q, acc_state_d;
  logic                      in_ready_q, in_ready_d;
  logic                      busy_q, busy_d;
  logic                      acc_valid_q, acc_valid_d;
  logic [PROD_W*LANES-1:0]   prod_c;
  logic [SUM_W-1:0]          sum_c;
  logic                      accept_c;

  fc_mac_lanes u_mac (
    .act_i    (act),
    .wgt_i    (wgt),
    .prod_q_i (prod_q),
    .prod_o   (prod_c),
    .sum_o    (sum_c)
  );

  assign accept_c = in_valid && in_ready_q;

  // Stage 2 runs every cycle; prod_q is zero unless it holds an accepted beat.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q + {{(ACC_W-SUM_W){sum_c[SUM_W-1]}}, sum_c};
    prod_d      = '0;
    acc_data_d  = acc_data_q;
    acc_state_d = acc_state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_ACCUM;
          acc_d       = bias;
          acc_state_d = fc_state;
          cnt_d       = '0;
        end
      end
      ST_ACCUM: begin
        if (accept_c) begin
          prod_d = prod_c;
          cnt_d  = CNT_W'(cnt_q + 1'b1);
          if (cnt_q == last_beat(acc_state_q)) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        acc_data_d = acc_d;
        state_d    = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    in_ready_d  = (state_d == ST_ACCUM);
    busy_d      = (state_d != ST_IDLE);
    acc_valid_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      prod_q      <= '0;
      acc_data_q  <= '0;
      acc_state_q <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      acc_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      prod_q      <= prod_d;
      acc_data_q  <= acc_data_d;
      acc_state_q <= acc_state_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      acc_valid_q <= acc_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign acc_valid = acc_valid_q;
  assign acc_data  = acc_data_q;
  assign acc_state = acc_state_q;

endmodule

// File: tb/tb_fc_accumulator.sv
// Bench for fc_accumulator: job-level reference model compared every cycle,
// plus hand-computed results for the directed jobs.
module tb_fc_accumulator;

  logic        clk = 1'b0;
  logic        srst;
  logic        fc_state;
  logic        start;
  logic [31:0] bias;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] act;
  logic [31:0] wgt;
  logic        busy;
  logic        acc_valid;
  logic [31:0] acc_data;
  logic        acc_state;

  int checks = 0;
  int failures = 0;
  int jobs_done = 0;
  int pulses_seen = 0;

  // Reference model: beats still owed, cycles left until the result, running sum.
  bit          armed = 1'b0;
  int          m_left = 0;
  int          m_tail = 0;
  logic [31:0] m_sum = '0;
  logic        m_st = 1'b0;
  logic [31:0] exp_data = '0;
  logic        exp_st = 1'b0;

  fc_accumulator dut (
    .clk       (clk),
    .srst      (srst),
    .fc_state  (fc_state),
    .start     (start),
    .bias      (bias),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .act       (act),
    .wgt       (wgt),
    .busy      (busy),
    .acc_valid (acc_valid),
    .acc_data  (acc_data),
    .acc_state (acc_state)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] dot4(input logic [31:0] a, input logic [31:0] w);
    int s;
    logic signed [7:0] x;
    logic signed [7:0] y;
    s = 0;
    for (int i = 0; i < 4; i++) begin
      x = a[8*i +: 8];
      y = w[8*i +: 8];
      s = s + int'(x) * int'(y);
    end
    return 32'(s);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s t=%0t got=%0d (0x%08h) want=%0d (0x%08h)", name, $time,
                 $signed(got), got, $signed(want), want);
    end
  endtask

  always @(posedge clk) begin
    if (srst) begin
      armed    = 1'b1;
      m_left   = 0;
      m_tail   = 0;
      m_sum    = '0;
      exp_data = '0;
    end else if (m_left == 0 && m_tail == 0) begin
      if (start) begin
        m_left = fc_state ? 125 : 200;
        m_sum  = bias;
        m_st   = fc_state;
      end
    end else if (m_left > 0) begin
      if (in_valid) begin
        m_sum  = m_sum + dot4(act, wgt);
        m_left = m_left - 1;
        if (m_left == 0) m_tail = 2;
      end
    end else begin
      m_tail = m_tail - 1;
      if (m_tail == 1) begin
        exp_data = m_sum;
        exp_st   = m_st;
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("in_ready", 32'(in_ready), 32'(m_left > 0));
      chk("busy", 32'(busy), 32'(m_left > 0 || m_tail > 0));
      chk("acc_valid", 32'(acc_valid), 32'(m_tail == 1));
      chk("acc_data", acc_data, exp_data);
      if (m_tail == 1) chk("acc_state", 32'(acc_state), 32'(exp_st));
      if (acc_valid === 1'b1) pulses_seen++;
    end
  end

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      start    = 1'b0;
      in_valid = 1'($urandom_range(1));
      act      = $urandom;
      wgt      = $urandom;
      @(posedge clk) #1;
    end
  endtask

  // Drives one job starting in the current (IDLE) cycle; returns in the IDLE
  // cycle after DONE, or the cycle after reset when abort_at >= 0.
  task automatic run_job(input logic st, input logic [31:0] b, input logic [31:0] ap,
                         input logic [31:0] wp, input bit rnd, input int gap, input bit rob,
                         input bit lit_on, input logic [31:0] lit, input int abort_at);
    int n;
    int cnt;
    bit tog;
    bit v;
    start    = 1'b1;
    fc_state = st;
    bias     = b;
    in_valid = 1'($urandom_range(1));
    act      = $urandom;
    wgt      = $urandom;
    @(posedge clk) #1;
    start    = 1'b0;
    fc_state = 1'($urandom_range(1));
    bias     = $urandom;
    n   = st ? 125 : 200;
    cnt = 0;
    tog = 1'b1;
    while (cnt < n) begin
      if (abort_at >= 0 && cnt == abort_at) begin
        srst     = 1'b1;
        in_valid = 1'b1;
        @(posedge clk) #1;
        srst     = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(acc_valid), 32'd0);
        chk("rst_data", acc_data, 32'd0);
        @(posedge clk) #1;
        return;
      end
      case (gap)
        0: v = 1'b1;
        1: begin v = tog; tog = ~tog; end
        default: v = ($urandom_range(2) != 0);
      endcase
      in_valid = v;
      act      = (v && !rnd) ? ap : $urandom;
      wgt      = (v && !rnd) ? wp : $urandom;
      start    = rob ? 1'($urandom_range(1)) : 1'b0;
      if (v) cnt++;
      @(posedge clk) #1;
    end
    start    = rob;
    in_valid = rob;
    act      = $urandom;
    wgt      = $urandom;
    @(posedge clk) #1;
    start    = rob;
    in_valid = rob;
    @(negedge clk);
    chk("done_valid", 32'(acc_valid), 32'd1);
    chk("done_ready", 32'(in_ready), 32'd0);
    chk("done_state", 32'(acc_state), 32'(st));
    if (lit_on) chk("done_literal", acc_data, lit);
    jobs_done++;
    @(posedge clk) #1;
    start    = 1'b0;
    in_valid = 1'($urandom_range(1));
  endtask

  initial begin
    srst = 1'b1; start = 1'b0; fc_state = 1'b0; bias = '0;
    in_valid = 1'b0; act = '0; wgt = '0;
    repeat (3) @(posedge clk);
    #1 srst = 1'b0;
    @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_ready", 32'(in_ready), 32'd0);
    chk("reset_valid", 32'(acc_valid), 32'd0);
    chk("reset_data", acc_data, 32'd0);
    chk("reset_state", 32'(acc_state), 32'd0);
    @(posedge clk) #1;
    idle(2);

    run_job(1'b1, 32'd100, 32'h01010101, 32'h02020202, 0, 0, 0, 1, 32'd1100, -1);
    idle(3);
    run_job(1'b0, 32'(-50), 32'h04030201, 32'hFFFFFFFF, 0, 1, 0, 1, 32'(-2050), -1);
    idle(2);
    run_job(1'b0, 32'd0, 32'h80808080, 32'h80808080, 0, 0, 0, 1, 32'd13107200, -1);
    idle(1);
    run_job(1'b0, 32'd0, 32'h7F7F7F7F, 32'h80808080, 0, 2, 0, 1, 32'(-13004800), -1);
    idle(2);
    run_job(1'b1, 32'd5, 32'h03030303, 32'hFDFDFDFD, 0, 2, 1, 1, 32'(-4495), -1);
    idle(2);
    run_job(1'b0, 32'd1234, 32'h0, 32'h0, 1, 2, 0, 0, 32'd0, 60);
    idle(1);
    run_job(1'b1, 32'd7, 32'h00000000, 32'hA5A5A5A5, 0, 2, 0, 1, 32'd7, -1);
    idle(1);
    run_job(1'b0, 32'd1000, 32'hFEFEFEFE, 32'h05050505, 0, 0, 0, 1, 32'(-7000), -1);
    run_job(1'b1, $urandom, 32'h0, 32'h0, 1, 2, 1, 0, 32'd0, -1);
    for (int j = 0; j < 3; j++) begin
      idle($urandom_range(3));
      run_job(1'($urandom_range(1)), $urandom, 32'h0, 32'h0, 1, 2, 1, 0, 32'd0, -1);
    end
    idle(4);
    chk("pulse_count", 32'(pulses_seen), 32'(jobs_done));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog t=%0t got=timeout want=finish", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fc_accumulator.md
Name: fc_accumulator

Overview:
- Multiply-accumulate stage for the FC layers. Computes one output neuron per job: bias plus the dot product of an 8-bit activation vector and an 8-bit weight vector.
- Sits directly upstream of the FC quantizer. Its 32-bit acc_data/acc_valid result is the quantizer's unquantized input, and acc_state tells the quantizer which layer (FC1/FC2) produced it.
- Consumes LANES activation/weight pairs per accepted beat. The number of beats per neuron is fixed by layer.

Parameters:
- LANES, 4, number of activation/weight pairs consumed per beat.
- FC1_BEATS, 200, beats per neuron in FC1 (800 inputs / 4 lanes).
- FC2_BEATS, 125, beats per neuron in FC2 (500 inputs / 4 lanes).
- ACC_W, 32, accumulator and result width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- srst  in  1  synchronous reset, active-high.
- fc_state  in  1  layer select, sampled on start; 0 = FC1, 1 = FC2.
- start  in  1  single-cycle job request; honoured only in IDLE.
- bias  in  ACC_W  signed bias, pre-scaled to accumulator units; sampled on start.
- in_valid  in  1  activation/weight beat present.
- in_ready  out  1  high exactly while in ACCUM.
- act  in  8*LANES  packed signed activations; lane i = bits [8i+7:8i].
- wgt  in  8*LANES  packed signed weights; same lane packing as act.
- busy  out  1  high in every state except IDLE.
- acc_valid  out  1  single-cycle pulse; acc_data is final in that cycle.
- acc_data  out  ACC_W  signed result; holds its value until the next acc_valid.
- acc_state  out  1  fc_state latched at start; held with acc_data.

Behaviour:
- Reset (srst = 1 at a clock edge): state = IDLE. in_ready, busy, acc_valid = 0. acc_data = 0, acc_state = 0. Accumulator, beat counter and product registers = 0.
- Reset has priority over all other inputs, including mid-job. A job interrupted by reset is abandoned and produces no acc_valid.
- Beat accepted = in_valid && in_ready.
- FSM states: IDLE, ACCUM, DRAIN, DONE.
- IDLE:
  - start = 1 → ACCUM. Load accumulator = bias, latch fc_state into acc_state, clear beat counter.
  - in_valid in IDLE is ignored.
- ACCUM:
  - Per accepted beat: register LANES signed 8x8 products, each 16 bits. Increment beat counter.
  - Idle cycles (in_valid = 0) are allowed anywhere in the job; the counter holds.
  - Acceptance of beat number N-1 (counting from 0) → DRAIN. N = FC1_BEATS or FC2_BEATS per the latched fc_state.
- Pipeline:
  - Stage 1 registers the products.
  - Stage 2 sign-extends the products, sums them and adds the sum to the accumulator.
  - Sum width: 16 + clog2(LANES) bits, sign-extended to ACC_W.
  - The accumulator wraps modulo 2^ACC_W with no saturation. Saturation belongs to the quantizer; worst-case FC1 magnitude (800*128*128 ≈ 1.3e7) fits in 32 bits anyway.
- DRAIN (1 cycle): stage 2 folds in the last beat's products. in_ready = 0. Unconditional → DONE.
- DONE (1 cycle): acc_valid = 1 and acc_data = final accumulator value (registered). Unconditional → IDLE.
- Latency: last beat accepted in cycle T → acc_valid in cycle T+2.
- start is ignored whenever state ≠ IDLE. start asserted in the DONE cycle is also ignored; it is accepted on the following cycle, when the FSM is back in IDLE.
- Back-to-back jobs: minimum spacing is 1 IDLE cycle between DONE and the next ACCUM.
- Stage-1 products not belonging to an accepted beat must be zero, so idle cycles add nothing to the accumulator.
- fc_state and bias changes after start have no effect on the running job.

Decomposition:
- Shared package fc_pkg holds:
  - FC1_STATE = 0, FC2_STATE = 1, common with the quantizer;
  - FC1_BEATS and FC2_BEATS;
  - ACC_W;
  - the FSM state encoding (2-bit IDLE/ACCUM/DRAIN/DONE).
- One sub-module, fc_mac_lanes: combinational LANES-way signed multiply and adder tree, producing the beat sum. The stage registers and FSM stay in fc_accumulator.

Test Plan:
- FC2 job: bias = 100; all 125 beats with act = 1, wgt = 2 in every lane → acc_valid exactly 2 cycles after the last beat; acc_data = 100 + 125*4*2 = 1100; acc_state = 1.
- FC1 job with in_valid toggling every other cycle: bias = -50; 200 beats with lanes act = {1,2,3,4}, wgt = {-1,-1,-1,-1} → acc_data = -50 - 200*10 = -2050; in_ready low in IDLE, DRAIN and DONE.
- Extremes: FC1, bias = 0, every lane act = -128, wgt = -128 → acc_data = 200*4*16384 = 13107200; act = 127, wgt = -128 → acc_data = -13004800.
- Control robustness: start pulses during ACCUM and in DONE, plus in_valid beats in IDLE, DRAIN and DONE → no effect on acc_data; only one acc_valid per accepted start.
- Reset mid-job: srst at beat 60 of an FC1 job → next cycle busy = 0, acc_valid = 0, acc_data = 0. A fresh FC2 job (bias = 7, all products 0) then gives acc_data = 7.
- Back-to-back: FC1 job then FC2 job, start issued on the cycle after DONE → two acc_valid pulses, each with the correct acc_state and value; no carry-over of accumulator or counter between jobs.
